mem_data_interface: RTL and testbench

- Memory-side stage of the single-bus datapath. Captures the bus value into the MAR and MDR. Runs the read/write handshake with memory.
- Drives the MDR contents back out as one of the 32-bit source inputs of the bus multiplexer.
- Consumes the multiplexer's bus_contents. Produces the mdr_out source word.

---
 rtl/mem_data_interface.sv | 148 ++++++++++++++
 tb/tb_mem_data_interface.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_interface.sv
// Memory-side stage of the single-bus datapath.
// Holds the MAR/MDR pair loaded from the bus and runs the read/write
// handshake with memory, aborting a request that is not acknowledged in time.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request; MAR/MDR loads and new starts are accepted
// RD    | mem_rd asserted; waiting for mem_ack, MDR captures mem_rdata
// WR    | mem_wr asserted; waiting for mem_ack, MDR is driven as write data
module mem_data_interface #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16   // legal range 2..255
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [31:0]       bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              read_start,
  input  logic              write_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  // Last counter value before the abort; the request then stays high
  // for exactly TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [31:0]         mdr_q, mdr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // Register all state and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output decode for the handshake FSM.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        // Loads land on the same edge as a start, so the request that rises
        // next cycle already sees the new address/data.
        if (mar_in) mar_d = bus_in[ADDR_W-1:0];
        if (mdr_in) mdr_d = bus_in;
        if (read_start) begin
          state_d = RD;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (write_start) begin
          state_d = WR;
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end

      RD, WR: begin
        // An ack wins over a coincident timeout.
        if (mem_ack) begin
          if (state_q == RD) mdr_d = mem_rdata;
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mdr_out   = mdr_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_data_interface.sv
// Self-checking bench for mem_data_interface: directed cases followed by
// randomized transactions against a transaction-level reference model.
module tb_mem_data_interface;

  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              clr_n;
  logic [31:0]       bus_in;
  logic              mar_in, mdr_in, read_start, write_start;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata, mdr_out;
  logic              mem_rd, mem_wr, mem_ack, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what MAR, MDR and err should hold in IDLE.
  logic [ADDR_W-1:0] mar_m;
  logic [31:0]       mdr_m;
  logic              err_m;

  mem_data_interface #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr_n(clr_n), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .read_start(read_start), .write_start(write_start), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mdr_out(mdr_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mar_in = 1'b0; mdr_in = 1'b0; read_start = 1'b0; write_start = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_addr"},  32'(mem_addr), 32'(mar_m));
    chk({tag, "_wdata"}, mem_wdata, mdr_m);
    chk({tag, "_mdr"},   mdr_out, mdr_m);
    chk({tag, "_req"},   32'({mem_rd, mem_wr}), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_err"},   32'(err), 32'(err_m));
  endtask

  // IDLE load, optionally with a stray ack that must be ignored.
  task automatic load(input bit m, input bit d, input logic [31:0] v, input bit ack_noise);
    mar_in = m; mdr_in = d; bus_in = v;
    mem_ack = ack_noise; mem_rdata = $urandom;
    tick();
    clear_inputs();
    if (m) mar_m = v[ADDR_W-1:0];
    if (d) mdr_m = v;
    check_idle("load");
    chk("load_done", 32'(done), 32'd0);
  endtask

  // One transaction; k = cycle of the request in which ack is given
  // (0 or > TIMEOUT means no ack, i.e. a timeout abort).
  task automatic txn(input bit is_rd, input bit both, input int k, input logic [31:0] rd_val);
    int req_cycles;
    bit seen;
    bit acked;
    req_cycles = 0;
    seen = 1'b0;
    read_start = is_rd;
    write_start = !is_rd || both;
    bus_in = $urandom;
    tick();
    clear_inputs();
    chk("start_req", 32'({mem_rd, mem_wr}), is_rd ? 32'd2 : 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_err_clr", 32'(err), 32'd0);
    chk("start_addr", 32'(mem_addr), 32'(mar_m));
    for (int c = 1; c <= TIMEOUT + 10 && !seen; c++) begin
      if (mem_rd || mem_wr) req_cycles++;
      mem_ack = (c == k);
      mem_rdata = (c == k) ? rd_val : $urandom;
      mar_in = 1'($urandom_range(0, 1));
      mdr_in = 1'($urandom_range(0, 1));
      read_start = 1'($urandom_range(0, 1));
      write_start = 1'($urandom_range(0, 1));
      bus_in = $urandom;
      tick();
      clear_inputs();
      if (done) seen = 1'b1;
    end
    acked = (k >= 1) && (k <= TIMEOUT);
    chk("done_seen", 32'(seen), 32'd1);
    chk("req_cycles", 32'(req_cycles), acked ? 32'(k) : 32'(TIMEOUT));
    if (acked && is_rd) mdr_m = rd_val;
    err_m = !acked;
    check_idle("end");
    tick();
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    clr_n = 1'b0;
    bus_in = '0;
    mem_rdata = '0;
    clear_inputs();
    mar_m = '0; mdr_m = '0; err_m = 1'b0;
    #12;
    check_idle("rst");
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;

    load(1'b1, 1'b0, 32'h0000_01A5, 1'b0);
    chk("mar_1a5", 32'(mem_addr), 32'h1A5);
    load(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("mdr_deadbeef", mdr_out, 32'hDEADBEEF);

    load(1'b1, 1'b0, 32'h0000_0010, 1'b0);
    txn(1'b1, 1'b0, 3, 32'h1234_5678);
    chk("rd_mdr", mdr_out, 32'h12345678);

    load(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    txn(1'b0, 1'b0, 1, 32'h5555_AAAA);
    chk("wr_mdr", mem_wdata, 32'hCAFEF00D);

    txn(1'b1, 1'b0, 0, 32'h0BAD_0BAD);
    chk("to_err", 32'(err), 32'd1);
    chk("to_mdr", mdr_out, 32'hCAFEF00D);
    txn(1'b0, 1'b0, TIMEOUT, 32'h0);
    chk("edge_ack_err", 32'(err), 32'd0);

    txn(1'b1, 1'b1, 2, 32'h0F0F_1234);

    // Load and start in the same cycle: request sees the new values.
    mar_in = 1'b1; mdr_in = 1'b1; write_start = 1'b1; bus_in = 32'hA5A5_0123;
    tick();
    clear_inputs();
    mar_m = 9'h123; mdr_m = 32'hA5A5_0123;
    chk("same_addr", 32'(mem_addr), 32'h123);
    chk("same_wdata", mem_wdata, 32'hA5A50123);
    chk("same_wr", 32'(mem_wr), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("same_done", 32'(done), 32'd1);

    // Back-to-back: start accepted in the done cycle.
    write_start = 1'b1;
    tick();
    write_start = 1'b0;
    chk("b2b_wr", 32'(mem_wr), 32'd1);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("b2b_done2", 32'(done), 32'd1);
    check_idle("b2b");
    tick();

    for (int i = 0; i < 40; i++) begin
      load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)));
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, TIMEOUT + 3), $urandom);
    end

    // Reset mid-read, then a late ack must do nothing.
    load(1'b1, 1'b1, 32'h7777_00FF, 1'b0);
    read_start = 1'b1;
    tick();
    read_start = 1'b0;
    tick();
    #2;
    clr_n = 1'b0;
    #1;
    mar_m = '0; mdr_m = '0; err_m = 1'b0;
    check_idle("mid_rst");
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h9999_9999;
    tick();
    mem_ack = 1'b0;
    check_idle("late_ack");
    chk("late_ack_done", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
